mbus_master: RTL and testbench
==============================

MBUS_MASTER -- requirements
Module: mbus_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 20000, response timeout in clk cycles, counted from tx_start.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle command request, sampled only in IDLE.
- cmd_mode  in  8  mode byte; bit0=1 write (payload sent), bit0=0 read.
- cmd_rack  in  3  destination rack id.
- cmd_slot  in  4  destination slot id.
- cmd_addr  in  24  target address in card RAM.
- cmd_len  in  11  write: payload bytes sent; read: data bytes expected.
- src_rden / src_raddr / src_rdata  out / out / in  1 / 11 / 8  payload source RAM, 1-cycle read latency.
- tx_buf_wren / tx_buf_waddr / tx_buf_wdata  out  1 / 11 / 8  link transmit buffer write.
- tx_data_len  out  11  frame length in bytes.
- tx_start  out  1  one-cycle frame send pulse.
- rx_start / rx_done  in  1 / 1  link receive frame begin / complete pulses.
- rx_crc_rslt  in  2  2'b01 = CRC pass, any other value = fail; valid with rx_done.
- rx_buf_rden / rx_buf_raddr / rx_buf_rdata  out / out / in  1 / 11 / 8  receive buffer read, 1-cycle latency.
- rsp_wren / rsp_waddr / rsp_wdata  out  1 / 11 / 8  response data RAM write.
- busy  out  1  high from accepted cmd_start until done.
- done  out  1  one-cycle completion pulse.
- status  out  3  0 OK, 1 timeout, 2 CRC error, 3 header mismatch, 4 length error; held until the next accepted command.

Function
REQ-003 States: IDLE, HDR, PLD, KICK, WAIT, RHDR, RDAT, FIN.
REQ-004 IDLE: cmd_start latches all cmd_* fields and sets busy next cycle; cmd_start is ignored outside IDLE.
REQ-005 Length check: cmd_len > 2042 -> no tx or rx activity; FIN with status 4.
REQ-006 HDR: write 5 bytes, one per cycle, to tx_buf addr 0..4: {1'b0,rack,slot}, mode, addr[23:16], addr[15:8], addr[7:0].
REQ-007 PLD (write only, cmd_len>0): src_raddr 0..cmd_len-1 issued on consecutive cycles; byte k is written to tx_buf addr 5+k one cycle after its read; no gaps.
REQ-008 Read command or cmd_len=0: skip PLD.
REQ-009 KICK: tx_start pulses for 1 cycle, the cycle after the last tx_buf write; tx_data_len = 5 + (write ? cmd_len : 0), valid from tx_start and held until the next command.
REQ-010 WAIT: timeout counter cleared at tx_start and incremented each cycle; reaching TIMEOUT_CYC -> FIN, status 1.
REQ-011 In WAIT, rx_done with rx_crc_rslt != 2'b01 -> FIN, status 2; with 2'b01 -> RHDR.
REQ-012 rx_done and timeout in the same cycle: rx_done wins.
REQ-013 rx_start is ignored; rx_done outside WAIT is ignored.
REQ-014 RHDR/RDAT: read rx_buf addr 0..N+1 on consecutive cycles, N = write ? 0 : cmd_len.
REQ-015 Byte0 must equal {1'b1,rack,slot} and byte1 must equal mode; on any mismatch -> FIN, status 3, with zero rsp_wren pulses.
REQ-016 Data byte k (rx addr 2+k) is written to rsp_waddr k one cycle after its read.
REQ-017 FIN: done pulses 1 cycle; busy drops in the same cycle; return to IDLE; status OK if no error occurred.
REQ-018 All address counters are 11-bit; no wrap occurs because of REQ-005.

Reset
REQ-019 On reset low, asynchronously: state IDLE; all outputs 0, including status, tx_data_len, and all addresses; timeout counter 0.
REQ-020 Reset mid-operation aborts the command: no done, no further writes, and tx_start is not generated.
REQ-021 Operation resumes on the first clk edge after reset release; the first accepted cmd_start starts a clean command.

Verification
REQ-022 Write, rack 2, slot 5, mode 8'h01, addr 24'h123456, len 3, src 11/22/33 -> tx_buf bytes 25,01,12,34,56,11,22,33; tx_data_len 8; rx reply 8'hA5,8'h01 with CRC 01 -> done, status 0, no rsp_wren.
REQ-023 Read, len 4, reply A5,00,DE,AD,BE,EF with CRC 01 -> rsp addr 0..3 = DE,AD,BE,EF; status 0.
REQ-024 No rx_done for TIMEOUT_CYC cycles after tx_start -> done exactly TIMEOUT_CYC cycles after tx_start, status 1; a late rx_done is ignored.
REQ-025 rx_done with rx_crc_rslt 2'b10 -> status 2; reply byte0 8'hA6 -> status 3, no rsp_wren.
REQ-026 cmd_len 2043 -> done, status 4, no tx_start; cmd_start while busy is ignored; reset low during PLD -> outputs 0, no done.

Source files
------------

// File: rtl/mbus_master_if.sv
// Command/link bundle for mbus_master.
// master modport: the mbus_master side. slave modport: the environment side
// (command issuer, payload source RAM, link transmit/receive buffers and the
// response RAM).
//   cmd_*          command request and fields, sampled when the master is idle
//   src_*          payload source RAM read port, 1-cycle read latency
//   tx_buf_*       link transmit buffer write port
//   tx_data_len    frame length in bytes
//   tx_start       frame send pulse
//   rx_*           link receive pulses, CRC result and receive buffer read port
//   rsp_*          response data RAM write port
//   busy/done      command in flight / completion pulse
//   status         completion code, held until the next accepted command
interface mbus_master_if;
  logic        cmd_start;
  logic [7:0]  cmd_mode;
  logic [2:0]  cmd_rack;
  logic [3:0]  cmd_slot;
  logic [23:0] cmd_addr;
  logic [10:0] cmd_len;
  logic        src_rden;
  logic [10:0] src_raddr;
  logic [7:0]  src_rdata;
  logic        tx_buf_wren;
  logic [10:0] tx_buf_waddr;
  logic [7:0]  tx_buf_wdata;
  logic [10:0] tx_data_len;
  logic        tx_start;
  logic        rx_start;
  logic        rx_done;
  logic [1:0]  rx_crc_rslt;
  logic        rx_buf_rden;
  logic [10:0] rx_buf_raddr;
  logic [7:0]  rx_buf_rdata;
  logic        rsp_wren;
  logic [10:0] rsp_waddr;
  logic [7:0]  rsp_wdata;
  logic        busy;
  logic        done;
  logic [2:0]  status;

  modport master (
    input  cmd_start, cmd_mode, cmd_rack, cmd_slot, cmd_addr, cmd_len,
    input  src_rdata, rx_start, rx_done, rx_crc_rslt, rx_buf_rdata,
    output src_rden, src_raddr,
    output tx_buf_wren, tx_buf_waddr, tx_buf_wdata, tx_data_len, tx_start,
    output rx_buf_rden, rx_buf_raddr,
    output rsp_wren, rsp_waddr, rsp_wdata,
    output busy, done, status
  );

  modport slave (
    output cmd_start, cmd_mode, cmd_rack, cmd_slot, cmd_addr, cmd_len,
    output src_rdata, rx_start, rx_done, rx_crc_rslt, rx_buf_rdata,
    input  src_rden, src_raddr,
    input  tx_buf_wren, tx_buf_waddr, tx_buf_wdata, tx_data_len, tx_start,
    input  rx_buf_rden, rx_buf_raddr,
    input  rsp_wren, rsp_waddr, rsp_wdata,
    input  busy, done, status
  );
endinterface

// File: rtl/mbus_master.sv
// Card-bus command master. Builds a 5-byte header plus optional write
// payload in the link transmit buffer, kicks the frame, waits for the reply
// (with timeout), validates the reply header and copies read data into the
// response RAM.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mbus_master_if.master (command, RAM ports, link, busy/done/status)
module mbus_master #(
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic               clk,
  input  logic               reset,
  mbus_master_if.master      bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, PLD, KICK, WAIT, RHDR, RDAT, FIN
  } state_t;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_TIMEOUT = 3'd1,
    ST_CRC     = 3'd2,
    ST_HDR     = 3'd3,
    ST_LEN     = 3'd4
  } status_t;

  state_t        state_q, state_d;
  status_t       status_q, status_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [10:0]   txlen_q, txlen_d;
  logic [7:0]    mode_q;
  logic [2:0]    rack_q;
  logic [3:0]    slot_q;
  logic [23:0]   addr_q;
  logic [10:0]   len_q;
  logic          ld_cmd;
  logic [7:0]    hdr_byte;
  logic          is_wr;
  logic [10:0]   n_rx;

  assign is_wr = mode_q[0];
  assign n_rx  = is_wr ? '0 : len_q;

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    hdr_byte = {1'b0, rack_q, slot_q};
      3'd1:    hdr_byte = mode_q;
      3'd2:    hdr_byte = addr_q[23:16];
      3'd3:    hdr_byte = addr_q[15:8];
      default: hdr_byte = addr_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    txlen_d  = txlen_q;
    ld_cmd   = 1'b0;

    bus.src_rden     = 1'b0;
    bus.src_raddr    = '0;
    bus.tx_buf_wren  = 1'b0;
    bus.tx_buf_waddr = '0;
    bus.tx_buf_wdata = '0;
    bus.tx_start     = 1'b0;
    bus.rx_buf_rden  = 1'b0;
    bus.rx_buf_raddr = '0;
    bus.rsp_wren     = 1'b0;
    bus.rsp_waddr    = '0;
    bus.rsp_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          ld_cmd = 1'b1;
          cnt_d  = '0;
          if (bus.cmd_len > 11'd2042) begin
            status_d = ST_LEN;
            state_d  = FIN;
          end else begin
            status_d = ST_OK;
            txlen_d  = bus.cmd_mode[0] ? 11'd5 + bus.cmd_len : 11'd5;
            state_d  = HDR;
          end
        end
      end

      HDR: begin
        bus.tx_buf_wren  = 1'b1;
        bus.tx_buf_waddr = cnt_q;
        bus.tx_buf_wdata = hdr_byte;
        if (cnt_q == 11'd4) begin
          cnt_d = '0;
          if (is_wr && len_q != '0) begin
            // First payload read overlaps the last header write so the
            // payload writes follow the header without a bubble.
            bus.src_rden = 1'b1;
            state_d      = PLD;
          end else begin
            state_d = KICK;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      // Write byte cnt (read last cycle) while reading byte cnt+1.
      PLD: begin
        bus.tx_buf_wren  = 1'b1;
        bus.tx_buf_waddr = 11'd5 + cnt_q;
        bus.tx_buf_wdata = bus.src_rdata;
        if (cnt_q + 11'd1 < len_q) begin
          bus.src_rden  = 1'b1;
          bus.src_raddr = cnt_q + 11'd1;
          cnt_d         = cnt_q + 11'd1;
        end else begin
          state_d = KICK;
        end
      end

      // tmr_q holds the number of cycles elapsed since tx_start.
      KICK: begin
        bus.tx_start = 1'b1;
        tmr_d        = TW'(1);
        state_d      = WAIT;
      end

      WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (bus.rx_done) begin
          if (bus.rx_crc_rslt == 2'b01) begin
            cnt_d   = '0;
            state_d = RHDR;
          end else begin
            status_d = ST_CRC;
            state_d  = FIN;
          end
        end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = FIN;
        end
      end

      // Reads addr 0 and 1; each header byte is checked the cycle after its read.
      RHDR: begin
        case (cnt_q[1:0])
          2'd0: begin
            bus.rx_buf_rden  = 1'b1;
            bus.rx_buf_raddr = 11'd0;
            cnt_d            = 11'd1;
          end
          2'd1: begin
            bus.rx_buf_rden  = 1'b1;
            bus.rx_buf_raddr = 11'd1;
            if (bus.rx_buf_rdata != {1'b1, rack_q, slot_q}) begin
              status_d = ST_HDR;
              state_d  = FIN;
            end else begin
              cnt_d = 11'd2;
            end
          end
          default: begin
            if (bus.rx_buf_rdata != mode_q) begin
              status_d = ST_HDR;
              state_d  = FIN;
            end else if (n_rx != '0) begin
              bus.rx_buf_rden  = 1'b1;
              bus.rx_buf_raddr = 11'd2;
              cnt_d            = '0;
              state_d          = RDAT;
            end else begin
              state_d = FIN;
            end
          end
        endcase
      end

      RDAT: begin
        bus.rsp_wren  = 1'b1;
        bus.rsp_waddr = cnt_q;
        bus.rsp_wdata = bus.rx_buf_rdata;
        if (cnt_q + 11'd1 < n_rx) begin
          bus.rx_buf_rden  = 1'b1;
          bus.rx_buf_raddr = cnt_q + 11'd3;
          cnt_d            = cnt_q + 11'd1;
        end else begin
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      cnt_q    <= '0;
      tmr_q    <= '0;
      txlen_q  <= '0;
      mode_q   <= '0;
      rack_q   <= '0;
      slot_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      txlen_q  <= txlen_d;
      if (ld_cmd) begin
        mode_q <= bus.cmd_mode;
        rack_q <= bus.cmd_rack;
        slot_q <= bus.cmd_slot;
        addr_q <= bus.cmd_addr;
        len_q  <= bus.cmd_len;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE) && (state_q != FIN);
  assign bus.done        = (state_q == FIN);
  assign bus.status      = status_q;
  assign bus.tx_data_len = txlen_q;

endmodule

// File: tb/tb_mbus_master.sv
// Self-checking bench for mbus_master: expected transmit-buffer and
// response-RAM writes are queued when a command is issued and compared as
// the DUT produces them.
module tb_mbus_master;

  localparam int unsigned TO = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mbus_master_if bus();

  mbus_master #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0]  src_mem [0:2047];
  logic [7:0]  rx_mem  [0:2047];
  logic [18:0] exp_tx  [$];
  logic [18:0] exp_rsp [$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          txs_cnt = 0;
  int          done_cnt = 0;
  int          txs_cyc = 0;
  int          done_cyc = 0;
  logic [10:0] exp_len = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.src_rden)    bus.src_rdata    <= src_mem[bus.src_raddr];
  always @(posedge clk) if (bus.rx_buf_rden) bus.rx_buf_rdata <= rx_mem[bus.rx_buf_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.tx_buf_wren) begin
      if (exp_tx.size() == 0) check("tx_unexpected_wr", 32'(bus.tx_buf_wren), 32'd0);
      else check("tx_buf", 32'({bus.tx_buf_waddr, bus.tx_buf_wdata}), 32'(exp_tx.pop_front()));
    end
    if (bus.rsp_wren) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected_wr", 32'(bus.rsp_wren), 32'd0);
      else check("rsp", 32'({bus.rsp_waddr, bus.rsp_wdata}), 32'(exp_rsp.pop_front()));
    end
    if (bus.tx_start) begin
      txs_cnt++;
      txs_cyc = cyc;
      check("tx_data_len", 32'(bus.tx_data_len), 32'(exp_len));
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", 32'(bus.busy), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] mode, input logic [2:0] rack, input logic [3:0] slot,
                          input logic [23:0] addr, input logic [10:0] len);
    @(negedge clk);
    bus.cmd_mode  = mode;
    bus.cmd_rack  = rack;
    bus.cmd_slot  = slot;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_start = 1'b1;
    if (len <= 11'd2042) begin
      exp_tx.push_back({11'd0, 1'b0, rack, slot});
      exp_tx.push_back({11'd1, mode});
      exp_tx.push_back({11'd2, addr[23:16]});
      exp_tx.push_back({11'd3, addr[15:8]});
      exp_tx.push_back({11'd4, addr[7:0]});
      if (mode[0]) begin
        for (int k = 0; k < int'(len); k++)
          exp_tx.push_back({11'd5 + 11'(k), src_mem[k]});
        exp_len = 11'd5 + len;
      end else begin
        exp_len = 11'd5;
      end
    end
    @(negedge clk);
    bus.cmd_start = 1'b0;
    #1;
    check("busy_after_start", 32'(bus.busy), 32'(len <= 11'd2042));
  endtask

  task automatic wait_txs(input int base);
    for (int i = 0; i < 4000 && txs_cnt == base; i++) tick();
    check("tx_start_count", txs_cnt, base + 1);
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 4000 && done_cnt == base; i++) tick();
    check("done_count", done_cnt, base + 1);
  endtask

  task automatic reply(input logic [1:0] crc);
    @(negedge clk);
    bus.rx_start = 1'b1;
    @(negedge clk);
    bus.rx_start    = 1'b0;
    bus.rx_done     = 1'b1;
    bus.rx_crc_rslt = crc;
    @(negedge clk);
    bus.rx_done     = 1'b0;
    bus.rx_crc_rslt = 2'b00;
  endtask

  task automatic end_checks(input logic [2:0] st);
    check("status", 32'(bus.status), 32'(st));
    check("tx_left", exp_tx.size(), 0);
    check("rsp_left", exp_rsp.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb, db, c0;
    bus.cmd_start = 1'b0; bus.cmd_mode = '0; bus.cmd_rack = '0; bus.cmd_slot = '0;
    bus.cmd_addr = '0; bus.cmd_len = '0; bus.src_rdata = '0; bus.rx_buf_rdata = '0;
    bus.rx_start = 1'b0; bus.rx_done = 1'b0; bus.rx_crc_rslt = 2'b00;
    for (int i = 0; i < 2048; i++) begin
      src_mem[i] = 8'(i) ^ 8'h5A;
      rx_mem[i]  = '0;
    end
    src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_status", 32'(bus.status), 0);
    check("rst_tx_data_len", 32'(bus.tx_data_len), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Write, len 3; a cmd_start while busy must be ignored
    tb = txs_cnt; db = done_cnt;
    send_cmd(8'h01, 3'd2, 4'd5, 24'h123456, 11'd3);
    wait_txs(tb);
    @(negedge clk);
    bus.cmd_mode = 8'h00; bus.cmd_len = 11'd4; bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h01;
    reply(2'b01);
    wait_done(db);
    end_checks(3'd0);
    repeat (10) tick();
    check("busy_cmd_ignored_done", done_cnt, db + 1);
    check("busy_cmd_ignored_txs", txs_cnt, tb + 1);
    check("tx_data_len_held", 32'(bus.tx_data_len), 32'd8);

    // Read, len 4
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h00; rx_mem[2] = 8'hDE; rx_mem[3] = 8'hAD;
    rx_mem[4] = 8'hBE; rx_mem[5] = 8'hEF;
    exp_rsp.push_back({11'd0, 8'hDE}); exp_rsp.push_back({11'd1, 8'hAD});
    exp_rsp.push_back({11'd2, 8'hBE}); exp_rsp.push_back({11'd3, 8'hEF});
    send_cmd(8'h00, 3'd2, 4'd5, 24'hABCDEF, 11'd4);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd0);

    // rx_done in the last cycle before timeout wins
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'h93; rx_mem[1] = 8'h40; rx_mem[2] = 8'hC3; rx_mem[3] = 8'h3C;
    exp_rsp.push_back({11'd0, 8'hC3}); exp_rsp.push_back({11'd1, 8'h3C});
    send_cmd(8'h40, 3'd1, 4'd3, 24'h000100, 11'd2);
    wait_txs(tb);
    c0 = txs_cyc;
    while (cyc < c0 + int'(TO) - 1) @(negedge clk);
    bus.rx_done = 1'b1; bus.rx_crc_rslt = 2'b01;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.rx_crc_rslt = 2'b00;
    wait_done(db);
    end_checks(3'd0);

    // Timeout, then a late rx_done
    tb = txs_cnt; db = done_cnt;
    send_cmd(8'h40, 3'd1, 4'd3, 24'h000200, 11'd2);
    wait_txs(tb);
    wait_done(db);
    check("timeout_latency", done_cyc - txs_cyc, TO);
    end_checks(3'd1);
    reply(2'b01);
    repeat (5) tick();
    check("late_rx_no_done", done_cnt, db + 1);
    check("late_rx_status", 32'(bus.status), 32'd1);
    check("late_rx_busy", 32'(bus.busy), 0);

    // CRC error
    tb = txs_cnt; db = done_cnt;
    send_cmd(8'h00, 3'd2, 4'd5, 24'h000300, 11'd2);
    wait_txs(tb);
    reply(2'b10);
    wait_done(db);
    end_checks(3'd2);

    // Header byte0 mismatch
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA6; rx_mem[1] = 8'h00;
    send_cmd(8'h00, 3'd2, 4'd5, 24'h000400, 11'd3);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd3);

    // Header byte1 (mode) mismatch
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h01;
    send_cmd(8'h00, 3'd2, 4'd5, 24'h000500, 11'd3);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd3);

    // Length error
    tb = txs_cnt; db = done_cnt;
    send_cmd(8'h01, 3'd2, 4'd5, 24'h000600, 11'd2043);
    wait_done(db);
    end_checks(3'd4);
    repeat (3) tick();
    check("len_err_no_tx_start", txs_cnt, tb);

    // Write, len 0
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h03;
    send_cmd(8'h03, 3'd2, 4'd5, 24'h000700, 11'd0);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd0);

    // Write, len 2042 (maximum)
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h01;
    send_cmd(8'h01, 3'd2, 4'd5, 24'hFEDCBA, 11'd2042);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd0);

    // Reset during payload
    tb = txs_cnt; db = done_cnt;
    send_cmd(8'h01, 3'd2, 4'd5, 24'h000800, 11'd20);
    for (int i = 0; i < 100 && exp_tx.size() > 10; i++) tick();
    check("pld_reached", 32'(exp_tx.size() <= 10), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_tx.delete();
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_tx_wren", 32'(bus.tx_buf_wren), 0);
    check("mid_rst_src_rden", 32'(bus.src_rden), 0);
    check("mid_rst_tx_data_len", 32'(bus.tx_data_len), 0);
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (10) tick();
    check("mid_rst_no_done", done_cnt, db);
    check("mid_rst_no_tx_start", txs_cnt, tb);

    // Clean command after reset
    tb = txs_cnt; db = done_cnt;
    rx_mem[0] = 8'hA5; rx_mem[1] = 8'h01;
    send_cmd(8'h01, 3'd2, 4'd5, 24'h000900, 11'd2);
    wait_txs(tb);
    reply(2'b01);
    wait_done(db);
    end_checks(3'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
